// File: rtl/cac_settings_arbiter.sv
// cac_settings_arbiter
// Round-robin arbiter that shares the single-port settings RAM between
// NUM_REQ requesters. Each access is serialised as IDLE -> ACCESS -> RESP.
// A requester may set req_lock to keep the RAM for an atomic
// read-modify-write sequence. The lock is dropped when the owner releases
// req_lock, or after LOCK_TIMEOUT owner-idle cycles.
//
// Ports
//   clk_cac, rstb_cac          : clock, synchronous active-low reset
//   req_valid/we/lock          : per-requester request, write flag, lock hold
//   req_addr/req_wdata         : flattened per-requester payload
//   req_ready                  : one-cycle accept pulse (ACCESS cycle)
//   rsp_valid/rsp_err/rsp_rdata: one-cycle completion (RESP cycle)
//   mem_en/we/addr/wdata       : RAM port; mem_rdata arrives one cycle later
//   busy, grant_id             : status; grant_id holds the current/last winner
//   lock_timeout               : pulse when a lock is forcibly released
module cac_settings_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int RAM_LENGTH   = 64,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                            clk_cac,
    input  logic                            rstb_cac,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ-1:0]              req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic                            rsp_err,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic                            busy,
    output logic [2:0]                      grant_id,
    output logic                            lock_timeout
);
    // Requester vectors are padded to 8 entries so a 3-bit index always fits.
    localparam int MAX_REQ = 8;
    localparam int CNT_W   = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t                 r_state, w_state_next;
    logic [2:0]             r_ptr, w_ptr_next;
    logic [2:0]             r_winner, w_load_idx, w_rr_idx;
    logic                   r_we, r_lock, r_err, r_lock_timeout;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [CNT_W-1:0]       r_to_cnt, w_cnt_next;
    logic                   w_timeout_next, w_load, w_rr_found, w_legal;
    logic [3:0]             w_cand;

    logic [MAX_REQ-1:0]     w_valid, w_we, w_lock;
    logic [ADDR_WIDTH-1:0]  w_addr  [MAX_REQ];
    logic [DATA_WIDTH-1:0]  w_wdata [MAX_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_req
            if (gi < NUM_REQ) begin : g_live
                assign w_valid[gi] = req_valid[gi];
                assign w_we[gi]    = req_we[gi];
                assign w_lock[gi]  = req_lock[gi];
                assign w_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
                assign w_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pad
                assign w_valid[gi] = 1'b0;
                assign w_we[gi]    = 1'b0;
                assign w_lock[gi]  = 1'b0;
                assign w_addr[gi]  = '0;
                assign w_wdata[gi] = '0;
            end
        end
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_out
            assign req_ready[gi] = (r_state == ST_ACCESS) && (r_winner == 3'(gi));
            assign rsp_valid[gi] = (r_state == ST_RESP) && (r_winner == 3'(gi));
        end
    endgenerate

    // Round-robin search from r_ptr. Scanning from the farthest candidate
    // towards r_ptr lets the nearest valid requester overwrite the result.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_ptr} + 4'(k);
            if (w_cand >= 4'(NUM_REQ)) begin
                w_cand = w_cand - 4'(NUM_REQ);
            end
            if (w_valid[w_cand[2:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand[2:0];
            end
        end
    end

    assign w_legal = (32'(r_addr) < 32'(RAM_LENGTH));

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_cnt_next     = r_to_cnt;
        w_timeout_next = 1'b0;
        w_load         = 1'b0;
        w_load_idx     = r_winner;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rr_found) begin
                    w_load       = 1'b1;
                    w_load_idx   = w_rr_idx;
                    w_ptr_next   = (w_rr_idx == 3'(NUM_REQ - 1)) ? 3'd0 : w_rr_idx + 3'd1;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_next = ST_RESP;
            ST_RESP:   w_state_next = r_lock ? ST_LOCKED : ST_IDLE;
            ST_LOCKED: begin
                // Releasing the lock takes priority over a simultaneous request;
                // that request is re-arbitrated from IDLE.
                if (!w_lock[r_winner]) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (w_valid[r_winner]) begin
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_ACCESS;
                end else if (r_to_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_timeout_next = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_cnt_next = r_to_cnt + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_cac) begin
        if (!rstb_cac) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_winner       <= '0;
            r_we           <= 1'b0;
            r_lock         <= 1'b0;
            r_err          <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_to_cnt       <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_ptr          <= w_ptr_next;
            r_to_cnt       <= w_cnt_next;
            r_lock_timeout <= w_timeout_next;
            if (w_load) begin
                r_winner <= w_load_idx;
                r_we     <= w_we[w_load_idx];
                r_lock   <= w_lock[w_load_idx];
                r_addr   <= w_addr[w_load_idx];
                r_wdata  <= w_wdata[w_load_idx];
            end
            if (r_state == ST_ACCESS) begin
                r_err <= !w_legal;
            end
        end
    end

    // All outputs decode from registered state only.
    assign mem_en       = (r_state == ST_ACCESS) && w_legal;
    assign mem_we       = mem_en && r_we;
    assign mem_addr     = mem_en ? r_addr : '0;
    assign mem_wdata    = (mem_en && r_we) ? r_wdata : '0;
    assign rsp_err      = (r_state == ST_RESP) && r_err;
    assign rsp_rdata    = ((r_state == ST_RESP) && !r_we && !r_err) ? mem_rdata : '0;
    assign busy         = (r_state != ST_IDLE);
    assign grant_id     = r_winner;
    assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_cac_settings_arbiter.sv
module tb_cac_settings_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RL = 64;
    localparam int LT = 255;
    localparam int IW = $clog2(NR);

    logic                 clk_cac = 1'b0;
    logic                 rstb_cac;
    logic [NR-1:0]        req_valid, req_we, req_lock;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*DW-1:0]     req_wdata;
    logic [NR-1:0]        req_ready, rsp_valid;
    logic                 rsp_err;
    logic [DW-1:0]        rsp_rdata;
    logic                 mem_en, mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;
    logic                 busy;
    logic [2:0]           grant_id;
    logic                 lock_timeout;

    cac_settings_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RAM_LENGTH(RL), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk_cac(clk_cac), .rstb_cac(rstb_cac),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id), .lock_timeout(lock_timeout)
    );

    always #5 clk_cac = ~clk_cac;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    always @(posedge clk_cac) cyc++;

    // RAM behind the DUT port, one-cycle read latency
    logic [DW-1:0] ram [256];
    always @(posedge clk_cac) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic fail_bound(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s @cyc %0d: wait bound expired, got no event, expected one", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // Transaction-level view: at every decision point pick a winner, then
    // the accept cycle, the response cycle and one settle cycle follow.
    logic [DW-1:0] ref_mem [256];
    int            m_ptr, m_gid, m_idle, m_step, m_j;
    bit            m_locked, m_armed = 0, m_found, m_we, m_legal;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    logic [NR-1:0] exp_ready, exp_rsp_valid;
    logic          exp_rsp_err, exp_mem_en, exp_mem_we, exp_busy, exp_lto;
    logic [DW-1:0] exp_rdata, exp_mem_wdata;
    logic [AW-1:0] exp_mem_addr;
    logic [2:0]    exp_gid;

    task automatic m_clear();
        exp_ready = '0; exp_rsp_valid = '0; exp_rsp_err = 0; exp_mem_en = 0;
        exp_mem_we = 0; exp_busy = 0; exp_lto = 0; exp_rdata = '0;
        exp_mem_wdata = '0; exp_mem_addr = '0;
    endtask

    task automatic m_grant(input int w, input bit from_idle);
        m_gid = w;
        if (from_idle) m_ptr = (w + 1) % NR;
        m_we     = req_we[IW'(w)];
        m_addr   = req_addr[w*AW +: AW];
        m_wdata  = req_wdata[w*DW +: DW];
        m_locked = req_lock[IW'(w)];
        m_legal  = (int'(m_addr) < RL);
        m_idle   = 0;
        exp_ready[IW'(w)] = 1'b1;
        exp_busy = 1'b1;
        if (m_legal) begin
            exp_mem_en   = 1'b1;
            exp_mem_we   = m_we;
            exp_mem_addr = m_addr;
            if (m_we) exp_mem_wdata = m_wdata;
            m_rdata = ref_mem[m_addr];
            if (m_we) ref_mem[m_addr] = m_wdata;
        end
        m_step = 1;
    endtask

    always @(posedge clk_cac) begin
        m_clear();
        if (!rstb_cac) begin
            m_ptr = 0; m_gid = 0; m_idle = 0; m_step = 0; m_locked = 0;
            m_armed = 1;
        end else if (m_armed) begin
            if (m_step == 1) begin
                exp_busy = 1'b1;
                exp_rsp_valid[IW'(m_gid)] = 1'b1;
                exp_rsp_err = !m_legal;
                exp_rdata = (m_legal && !m_we) ? m_rdata : '0;
                m_step = 2;
            end else if (m_step == 2) begin
                exp_busy = m_locked;
                m_step = 0;
            end else if (!m_locked) begin
                m_found = 0;
                for (int k = 0; k < NR; k++) begin
                    m_j = (m_ptr + k) % NR;
                    if (!m_found && req_valid[IW'(m_j)]) begin
                        m_found = 1;
                        m_grant(m_j, 1'b1);
                    end
                end
            end else if (!req_lock[IW'(m_gid)]) begin
                m_locked = 0;
                m_idle = 0;
            end else if (req_valid[IW'(m_gid)]) begin
                m_grant(m_gid, 1'b0);
            end else begin
                m_idle++;
                if (m_idle == LT) begin
                    m_locked = 0;
                    m_idle = 0;
                    exp_lto = 1'b1;
                end else begin
                    exp_busy = 1'b1;
                end
            end
        end
        exp_gid = 3'(m_gid);
    end

    // Per-cycle compare against the model
    always @(negedge clk_cac) begin
        if (m_armed) begin
            check("req_ready",    32'(req_ready),    32'(exp_ready));
            check("rsp_valid",    32'(rsp_valid),    32'(exp_rsp_valid));
            check("rsp_err",      32'(rsp_err),      32'(exp_rsp_err));
            check("rsp_rdata",    32'(rsp_rdata),    32'(exp_rdata));
            check("mem_en",       32'(mem_en),       32'(exp_mem_en));
            check("mem_we",       32'(mem_we),       32'(exp_mem_we));
            check("mem_addr",     32'(mem_addr),     32'(exp_mem_addr));
            check("mem_wdata",    32'(mem_wdata),    32'(exp_mem_wdata));
            check("busy",         32'(busy),         32'(exp_busy));
            check("grant_id",     32'(grant_id),     32'(exp_gid));
            check("lock_timeout", 32'(lock_timeout), 32'(exp_lto));
        end
    end

    // Grant log and one line per completed transaction
    int g_id [$];
    int g_cyc [$];
    int mem_en_cnt = 0;
    always @(negedge clk_cac) begin
        if (mem_en) mem_en_cnt++;
        for (int i = 0; i < NR; i++) begin
            if (req_ready[IW'(i)]) begin
                g_id.push_back(i);
                g_cyc.push_back(cyc);
            end
            if (rsp_valid[IW'(i)])
                $display("txn: cyc %0d req %0d err=%0b rdata=%04h", cyc, i, rsp_err, rsp_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_cac);
        #1;
    endtask

    task automatic idle_all();
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic lock, input int addr, input int data);
        req_valid[IW'(i)] = 1'b1;
        req_we[IW'(i)]    = we;
        req_lock[IW'(i)]  = lock;
        req_addr[i*AW +: AW]  = AW'(addr);
        req_wdata[i*DW +: DW] = DW'(data);
    endtask

    task automatic do_reset();
        rstb_cac = 1'b0;
        step();
        step();
        rstb_cac = 1'b1;
        g_id.delete();
        g_cyc.delete();
    endtask

    task automatic wait_ready(input int i, input int limit, input string name);
        bit ok = 0;
        for (int k = 0; k < limit && !ok; k++) begin
            step();
            if (req_ready[IW'(i)]) ok = 1;
        end
        if (!ok) fail_bound(name);
    endtask

    task automatic wait_rsp(input int i, input int limit, input string name);
        bit ok = 0;
        for (int k = 0; k < limit && !ok; k++) begin
            step();
            if (rsp_valid[IW'(i)]) ok = 1;
        end
        if (!ok) fail_bound(name);
    endtask

    task automatic rand_req(input int i);
        int a;
        if ($urandom_range(7) == 0) a = int'($urandom_range(255, RL));
        else a = int'($urandom_range(RL - 1));
        set_req(i, 1'($urandom_range(1)), ($urandom_range(4) == 0), a, int'($urandom_range(16'hFFFF)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_rsp, c_to;
        bit seen;
        logic [DW-1:0] v;
        rstb_cac = 1'b0;
        idle_all();
        for (int i = 0; i < 256; i++) begin
            v = DW'($urandom);
            if (i == 5) v = 16'h1234;
            ram[i] <= v;
            ref_mem[i] = v;
        end

        // reset state
        do_reset();
        check("reset_busy", 32'(busy), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_mem_en", 32'(mem_en), 0);

        // single read: requester 2, addr 5
        set_req(2, 1'b0, 1'b0, 5, 0);
        step();
        check("rd_ready", 32'(req_ready), 32'h4);
        check("rd_mem_en", 32'(mem_en), 1);
        check("rd_mem_addr", 32'(mem_addr), 5);
        req_valid[2] = 1'b0;
        step();
        check("rd_rsp_valid", 32'(rsp_valid), 32'h4);
        check("rd_rsp_rdata", 32'(rsp_rdata), 32'h1234);
        check("rd_rsp_err", 32'(rsp_err), 0);
        step();

        // round robin: all requesters hold valid from reset
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, i, 0);
        do_reset();
        for (int k = 0; k < 15; k++) step();
        check("rr_count", (g_id.size() >= 5) ? 1 : 0, 1);
        if (g_id.size() >= 5) begin
            check("rr_g0", g_id[0], 0);
            check("rr_g1", g_id[1], 1);
            check("rr_g2", g_id[2], 2);
            check("rr_g3", g_id[3], 3);
            check("rr_g4", g_id[4], 0);
            for (int k = 1; k < 5; k++) check("rr_spacing", g_cyc[k] - g_cyc[k-1], 3);
        end

        // out-of-range write: requester 1, addr 64
        idle_all();
        do_reset();
        mem_en_cnt = 0;
        set_req(1, 1'b1, 1'b0, 64, 16'hBEEF);
        wait_ready(1, 10, "oor_ready");
        check("oor_mem_en", 32'(mem_en), 0);
        req_valid[1] = 1'b0;
        step();
        check("oor_rsp_valid", 32'(rsp_valid), 32'h2);
        check("oor_rsp_err", 32'(rsp_err), 1);
        check("oor_rsp_rdata", 32'(rsp_rdata), 0);
        step();
        check("oor_no_mem_en", mem_en_cnt, 0);

        // locked read-modify-write by requester 3, requester 0 waiting
        idle_all();
        do_reset();
        set_req(3, 1'b0, 1'b1, 10, 0);
        wait_ready(3, 10, "rmw_rd_ready");
        set_req(0, 1'b0, 1'b0, 3, 0);
        set_req(3, 1'b1, 1'b1, 10, 16'h5A5A);
        wait_ready(3, 10, "rmw_wr_ready");
        req_valid[3] = 1'b0;
        wait_rsp(3, 10, "rmw_wr_rsp");
        req_lock[3] = 1'b0;
        wait_ready(0, 10, "rmw_r0_ready");
        step();
        check("rmw_count", g_id.size(), 3);
        if (g_id.size() == 3) begin
            check("rmw_g0", g_id[0], 3);
            check("rmw_g1", g_id[1], 3);
            check("rmw_g2", g_id[2], 0);
        end
        req_valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // lock timeout: requester 1 holds the lock idle, requester 2 pending
        idle_all();
        do_reset();
        set_req(1, 1'b0, 1'b1, 1, 0);
        wait_ready(1, 10, "lto_ready1");
        req_valid[1] = 1'b0;
        set_req(2, 1'b0, 1'b0, 2, 0);
        wait_rsp(1, 10, "lto_rsp1");
        c_rsp = cyc;
        seen = 0;
        c_to = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            if (lock_timeout) begin
                seen = 1;
                c_to = cyc;
            end
        end
        if (!seen) fail_bound("lto_pulse");
        else check("lto_delay", c_to - c_rsp, LT + 1);
        wait_ready(2, 5, "lto_ready2");
        check("lto_grant_gap", cyc - c_to, 1);
        step();
        check("lto_count", g_id.size(), 2);
        if (g_id.size() == 2) check("lto_g1", g_id[1], 2);
        idle_all();
        for (int k = 0; k < 3; k++) step();

        // reset in the ACCESS cycle
        do_reset();
        set_req(2, 1'b0, 1'b0, 7, 0);
        wait_ready(2, 10, "rst_ready2");
        rstb_cac = 1'b0;
        set_req(0, 1'b0, 1'b0, 8, 0);
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        rstb_cac = 1'b1;
        g_id.delete();
        g_cyc.delete();
        wait_ready(0, 5, "rst_ready0");
        step();
        check("rst_first_grant", (g_id.size() > 0) ? g_id[0] : -1, 0);

        // randomized traffic
        idle_all();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (req_ready[IW'(i)]) begin
                    if ($urandom_range(1) == 1) rand_req(i);
                    else begin
                        req_valid[IW'(i)] = 1'b0;
                        if ($urandom_range(3) == 0) req_lock[IW'(i)] = 1'b0;
                    end
                end else if (!req_valid[IW'(i)]) begin
                    if ($urandom_range(3) == 0) rand_req(i);
                    else if ($urandom_range(7) == 0) req_lock[IW'(i)] = 1'b0;
                end
            end
        end
        idle_all();
        for (int k = 0; k < 5; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
